// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback and
// drives every datapath select and enable, with a bounded memory wait and sticky trap.
module multicycle_ctrl #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  input  logic       i_alu_zero,
  input  logic       i_alu_overflow,
  input  logic       i_mem_ready,
  output logic       o_pc_write,
  output logic [1:0] o_pc_src,
  output logic       o_ir_write,
  output logic       o_iord,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_reg_write,
  output logic       o_reg_dst,
  output logic       o_mem_to_reg,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic       o_ext_signed,
  output logic [3:0] o_alu_op,
  output logic       o_ovf_trap,
  output logic       o_trap,
  output logic [3:0] o_state
);

  localparam int CW = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_SLL = 6'h00;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_TRAP     = 4'd15
  } state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_wait_cnt;
  logic          r_ovf;

  logic w_funct_ok, w_r_addsub, w_wait_st, w_timeout;

  assign w_funct_ok = (i_funct == FN_ADD) || (i_funct == FN_SUB) || (i_funct == FN_AND) ||
                      (i_funct == FN_OR)  || (i_funct == FN_SLT) || (i_funct == FN_SLL);
  assign w_r_addsub = (i_funct == FN_ADD) || (i_funct == FN_SUB);
  assign w_wait_st  = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  // ready in the final allowed cycle still wins over the timeout
  assign w_timeout  = w_wait_st && !i_mem_ready && (r_wait_cnt == CW'(MEM_WAIT_MAX));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_wait_cnt <= '0;
      else if (w_wait_st && !i_mem_ready)
        r_wait_cnt <= r_wait_cnt + 1'b1;
      // overflow is sampled in EXEC so the WB decision ignores later flag changes
      if (r_state == S_R_EXEC)
        r_ovf <= i_alu_overflow && w_r_addsub;
      else if (r_state == S_I_EXEC)
        r_ovf <= i_alu_overflow && (i_opcode == OP_ADDI);
    end
  end

  always_comb begin
    w_next       = r_state;
    o_pc_write   = 1'b0;
    o_pc_src     = 2'd0;
    o_ir_write   = 1'b0;
    o_iord       = 1'b0;
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_reg_write  = 1'b0;
    o_reg_dst    = 1'b0;
    o_mem_to_reg = 1'b0;
    o_alu_src_a  = 2'd0;
    o_alu_src_b  = 2'd0;
    o_ext_signed = 1'b1;
    o_alu_op     = ALU_ADD;
    o_ovf_trap   = 1'b0;
    o_trap       = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_mem_read  = 1'b1;
        o_alu_src_b = 2'd1;
        if (i_mem_ready) begin
          o_ir_write = 1'b1;
          o_pc_write = 1'b1;
          w_next     = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_TRAP;
        end
      end
      S_DECODE: begin
        o_alu_src_b = 2'd3;
        case (i_opcode)
          OP_RTYPE:       w_next = w_funct_ok ? S_R_EXEC : S_TRAP;
          OP_LW, OP_SW:   w_next = S_MEM_ADDR;
          OP_BEQ:         w_next = S_BRANCH;
          OP_J:           w_next = S_JUMP;
          OP_ADDI, OP_ORI: w_next = S_I_EXEC;
          default:        w_next = S_TRAP;
        endcase
      end
      S_R_EXEC: begin
        o_alu_src_a = (i_funct == FN_SLL) ? 2'd2 : 2'd1;
        case (i_funct)
          FN_SUB:  o_alu_op = ALU_SUB;
          FN_AND:  o_alu_op = ALU_AND;
          FN_OR:   o_alu_op = ALU_OR;
          FN_SLT:  o_alu_op = ALU_SLT;
          FN_SLL:  o_alu_op = ALU_SLL;
          default: o_alu_op = ALU_ADD;
        endcase
        w_next = S_R_WB;
      end
      S_R_WB: begin
        o_reg_dst   = 1'b1;
        o_reg_write = !r_ovf;
        o_ovf_trap  = r_ovf;
        w_next      = S_FETCH;
      end
      S_I_EXEC: begin
        o_alu_src_a = 2'd1;
        o_alu_src_b = 2'd2;
        if (i_opcode == OP_ORI) begin
          o_alu_op     = ALU_OR;
          o_ext_signed = 1'b0;
        end
        w_next = S_I_WB;
      end
      S_I_WB: begin
        o_reg_write = !r_ovf;
        o_ovf_trap  = r_ovf;
        w_next      = S_FETCH;
      end
      S_MEM_ADDR: begin
        o_alu_src_a = 2'd1;
        o_alu_src_b = 2'd2;
        w_next      = (i_opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        o_iord     = 1'b1;
        o_mem_read = 1'b1;
        if (i_mem_ready)    w_next = S_MEM_WB;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_MEM_WB: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEM_WR: begin
        o_iord      = 1'b1;
        o_mem_write = 1'b1;
        if (i_mem_ready)    w_next = S_FETCH;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_BRANCH: begin
        o_alu_src_a = 2'd1;
        o_alu_op    = ALU_SUB;
        o_pc_src    = 2'd1;
        o_pc_write  = i_alu_zero;
        w_next      = S_FETCH;
      end
      S_JUMP: begin
        o_pc_src   = 2'd2;
        o_pc_write = 1'b1;
        w_next     = S_FETCH;
      end
      S_TRAP: begin
        o_trap = 1'b1;
        w_next = S_TRAP;
      end
      default: w_next = S_TRAP;
    endcase
  end

  assign o_state = r_state;

endmodule
